// File: rtl/rf_cmd_framer_pkg.sv
// rf_cmd_pkg: shared opcodes, error codes, framer states and header field positions
package rf_cmd_pkg;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_HDR = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam int HDR_OP_HI   = 7;
  localparam int HDR_OP_LO   = 6;
  localparam int HDR_RSV     = 5;
  localparam int HDR_ADDR_HI = 4;
  localparam int HDR_ADDR_LO = 0;
  typedef enum logic [1:0] {IDLE, DATA, ISSUE} state_t;
endpackage

// File: rtl/rf_cmd_framer_if.sv
// rf_cmd_framer_if: byte stream in, parallel register-file command out
interface rf_cmd_framer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) ();
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              err_pulse;
  logic [1:0]        err_code;
  logic              busy;
  modport slave (
    input  in_byte, in_valid, cmd_ready,
    output in_ready, cmd_valid, cmd_write, cmd_addr, cmd_data, err_pulse, err_code, busy
  );
  modport master (
    output in_byte, in_valid, cmd_ready,
    input  in_ready, cmd_valid, cmd_write, cmd_addr, cmd_data, err_pulse, err_code, busy
  );
endinterface

// File: rtl/rf_cmd_framer.sv
// rf_cmd_framer: parses header + MSB-first payload bytes into one register-file command
module rf_cmd_framer
  import rf_cmd_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 64,
  parameter int GAP_MAX = 255
) (
  input logic          clk,
  input logic          rst,
  rf_cmd_framer_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int BCW = NB > 1 ? $clog2(NB) : 1;
  localparam int GW  = $clog2(GAP_MAX + 1);
  state_t            state, state_n;
  logic [BCW-1:0]    bcnt;
  logic [GW-1:0]     gap;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              we, ep;
  logic [1:0]        ec;
  logic [1:0]        op;
  logic              in_fire, hdr_bad, last_byte, hdr_take, bad, timeout;
  assign op        = bus.in_byte[HDR_OP_HI:HDR_OP_LO];
  assign hdr_bad   = (op != OP_NOP && op != OP_WRITE && op != OP_READ) | bus.in_byte[HDR_RSV];
  assign last_byte = bcnt == BCW'(NB - 1);
  assign in_fire   = bus.in_valid & bus.in_ready;
  assign bus.in_ready  = ~rst & (state != ISSUE);
  assign bus.cmd_valid = state == ISSUE;
  assign bus.busy      = state != IDLE;
  assign bus.cmd_write = we;
  assign bus.cmd_addr  = addr;
  assign bus.cmd_data  = data;
  assign bus.err_pulse = ep;
  assign bus.err_code  = ec;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state plus header/timeout decode; a byte on the expiry cycle beats the timeout
  always_comb begin
    state_n  = state;
    hdr_take = 1'b0;
    bad      = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        bad      = in_fire & hdr_bad;
        hdr_take = in_fire & ~hdr_bad & (op != OP_NOP);
        state_n  = hdr_take ? (op == OP_WRITE ? DATA : ISSUE) : IDLE;
      end
      DATA: begin
        timeout = ~in_fire & (gap == GW'(GAP_MAX - 1));
        state_n = (in_fire & last_byte) ? ISSUE : timeout ? IDLE : DATA;
      end
      ISSUE:   state_n = bus.cmd_ready ? IDLE : ISSUE;
      default: state_n = IDLE;
    endcase
  end
  // command fields, payload shifter, byte/gap counters and error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      we   <= 1'b0;
      addr <= '0;
      data <= '0;
      bcnt <= '0;
      gap  <= '0;
      ep   <= 1'b0;
      ec   <= ERR_NONE;
    end else begin
      ep <= bad | timeout;
      ec <= bad ? ERR_BAD_HDR : timeout ? ERR_TIMEOUT : ec;
      if (hdr_take) begin
        we   <= op == OP_WRITE;
        addr <= ADDR_W'(bus.in_byte[HDR_ADDR_HI:HDR_ADDR_LO]);
        data <= '0;
        bcnt <= '0;
        gap  <= '0;
      end else if (state == DATA) begin
        gap <= (in_fire | timeout) ? '0 : gap + GW'(1);
        if (in_fire) begin
          data <= {data[DATA_W-9:0], bus.in_byte};
          bcnt <= last_byte ? '0 : bcnt + BCW'(1);
        end else if (timeout) begin
          data <= '0;
        end
      end
    end
  end
endmodule
